// File: rtl/mux_sync_launch.sv
// Launch side of a mux-ndff clock-domain crossing: captures one word, holds it
// stable on data_out, and frames it with an en_out window of HOLD cycles plus GAP idle cycles.
module mux_sync_launch #(
  parameter int DW   = 8,
  parameter int HOLD = 3,
  parameter int GAP  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [DW-1:0] data_out,
  output logic          en_out,
  output logic          busy,
  output logic [15:0]   sent_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);
  localparam logic [3:0] GAP_M1  = 4'(GAP - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          en_q, en_d;
  logic          rdy_q, rdy_d;
  logic [DW-1:0] data_q, data_d;
  logic [15:0]   sent_q, sent_d;
  logic          xfer;

  // rdy_q is only ever set in IDLE, so it alone qualifies the handshake.
  assign xfer = in_valid & rdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    rdy_d   = rdy_q;
    data_d  = data_q;
    sent_d  = sent_q;
    case (state_q)
      S_IDLE: begin
        rdy_d = 1'b1;
        if (xfer) begin
          data_d  = in_data;
          en_d    = 1'b1;
          state_d = S_HOLD;
          cnt_d   = HOLD_M1;
          rdy_d   = 1'b0;
          sent_d  = sent_q + 16'd1;
        end
      end
      S_HOLD: begin
        rdy_d = 1'b0;
        if (cnt_q == 4'd0) begin
          en_d    = 1'b0;
          state_d = S_GAP;
          cnt_d   = GAP_M1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_GAP: begin
        rdy_d = 1'b0;
        en_d  = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
        rdy_d   = 1'b0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
      data_q  <= '0;
      sent_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
      sent_q  <= sent_d;
    end
  end

  assign in_ready = rdy_q;
  assign data_out = data_q;
  assign en_out   = en_q;
  assign busy     = (state_q != S_IDLE);
  assign sent_cnt = sent_q;

endmodule

// File: tb/tb_mux_sync_launch.sv
// Bench for mux_sync_launch: a default build checked through a launch scoreboard,
// plus a HOLD=1/GAP=1 build for the minimum-spacing case.
module tb_mux_sync_launch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, en_out, busy;
  logic [7:0]  data_out;
  logic [15:0] sent_cnt;

  logic        in_valid_b = 1'b0;
  logic [7:0]  in_data_b = 8'h00;
  logic        in_ready_b, en_out_b, busy_b;
  logic [7:0]  data_out_b;
  logic [15:0] sent_cnt_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [15:0] exp_sent = 16'd0;
  logic [7:0]  sbq[$];
  logic        en_prev = 1'b0;
  int          run = 0;

  mux_sync_launch #(.DW(8), .HOLD(3), .GAP(3)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .data_out(data_out), .en_out(en_out),
    .busy(busy), .sent_cnt(sent_cnt)
  );

  mux_sync_launch #(.DW(8), .HOLD(1), .GAP(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_ready(in_ready_b), .data_out(data_out_b), .en_out(en_out_b),
    .busy(busy_b), .sent_cnt(sent_cnt_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard: each rising en_out window must present the next queued word
  // and last exactly three cycles unless reset cuts it short.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      en_prev = 1'b0;
      run = 0;
    end else begin
      if (en_out && !en_prev) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_launch: got data_out=%h with no word pending", data_out);
        end else begin
          e = sbq.pop_front();
          if (data_out !== e) begin
            errors++;
            $display("FAIL sb_data: got %h expected %h", data_out, e);
          end
        end
      end
      if (en_out) run++;
      if (!en_out && en_prev) begin
        checks++;
        if (run !== 3) begin
          errors++;
          $display("FAIL en_width: got %0d expected 3", run);
        end
        run = 0;
      end
      en_prev = en_out;
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks += 5;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", in_ready); end
    if (en_out !== 1'b0) begin errors++; $display("FAIL rst_en: got %b expected 0", en_out); end
    if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", data_out); end
    if (sent_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt: got %h expected 0000", sent_cnt); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
  endtask

  task automatic test_first_word;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    rst = 1'b0;
    @(negedge clk);
    checks += 3;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL first_ready: got %b expected 1", in_ready); end
    if (en_out !== 1'b0) begin errors++; $display("FAIL first_noxfer_en: got %b expected 0", en_out); end
    if (sent_cnt !== 16'h0) begin errors++; $display("FAIL first_noxfer_cnt: got %h expected 0000", sent_cnt); end
    sbq.push_back(8'hA5);
    exp_sent++;
    @(negedge clk);
    in_valid = 1'b0;
    checks += 3;
    if (en_out !== 1'b1) begin errors++; $display("FAIL first_en: got %b expected 1", en_out); end
    if (busy !== 1'b1) begin errors++; $display("FAIL first_busy: got %b expected 1", busy); end
    if (sent_cnt !== exp_sent) begin errors++; $display("FAIL first_cnt: got %h expected %h", sent_cnt, exp_sent); end
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      checks += 2;
      if (en_out !== (k <= 3)) begin errors++; $display("FAIL first_en_k%0d: got %b expected %b", k, en_out, (k <= 3)); end
      if (data_out !== 8'hA5) begin errors++; $display("FAIL first_data_k%0d: got %h expected a5", k, data_out); end
    end
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL first_ready_again: got %b expected 1", in_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL first_idle: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    int t1, t2;
    bit ok;
    in_valid = 1'b1;
    in_data  = 8'h11;
    sbq.push_back(8'h11);
    exp_sent++;
    t1 = cyc;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_data = 8'h22;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      checks++;
      if (data_out !== 8'h11) begin errors++; $display("FAIL b2b_hold_data: got %h expected 11", data_out); end
    end
    t2 = cyc;
    checks += 4;
    if (!ok) begin errors++; $display("FAIL b2b_timeout: got no ready expected ready"); end
    if (t2 - t1 !== 7) begin errors++; $display("FAIL b2b_spacing: got %0d expected 7", t2 - t1); end
    if (en_out !== 1'b0) begin errors++; $display("FAIL b2b_en_at_edge: got %b expected 0", en_out); end
    if (data_out !== 8'h11) begin errors++; $display("FAIL b2b_pre_data: got %h expected 11", data_out); end
    sbq.push_back(8'h22);
    exp_sent++;
    @(negedge clk);
    in_valid = 1'b0;
    checks += 2;
    if (data_out !== 8'h22) begin errors++; $display("FAIL b2b_post_data: got %h expected 22", data_out); end
    if (sent_cnt !== exp_sent) begin errors++; $display("FAIL b2b_cnt: got %h expected %h", sent_cnt, exp_sent); end
  endtask

  task automatic test_ignore;
    bit ok;
    wait_ready(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ign_timeout: got no ready expected ready"); end
    in_valid = 1'b1;
    in_data  = 8'h3C;
    sbq.push_back(8'h3C);
    exp_sent++;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks += 3;
      if (data_out !== 8'h3C) begin errors++; $display("FAIL ign_data_k%0d: got %h expected 3c", k, data_out); end
      if (sent_cnt !== exp_sent) begin errors++; $display("FAIL ign_cnt_k%0d: got %h expected %h", k, sent_cnt, exp_sent); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL ign_ready_k%0d: got %b expected 0", k, in_ready); end
      in_data = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (sent_cnt !== exp_sent) begin errors++; $display("FAIL ign_cnt_end: got %h expected %h", sent_cnt, exp_sent); end
  endtask

  task automatic test_reset_abort;
    bit ok;
    wait_ready(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_timeout: got no ready expected ready"); end
    in_valid = 1'b1;
    in_data  = 8'h5A;
    sbq.push_back(8'h5A);
    exp_sent++;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (en_out !== 1'b1) begin errors++; $display("FAIL abort_pre_en: got %b expected 1", en_out); end
    #2 rst = 1'b1;
    #1;
    exp_sent = 16'd0;
    checks += 5;
    if (en_out !== 1'b0) begin errors++; $display("FAIL abort_en: got %b expected 0", en_out); end
    if (data_out !== 8'h00) begin errors++; $display("FAIL abort_data: got %h expected 00", data_out); end
    if (sent_cnt !== 16'h0) begin errors++; $display("FAIL abort_cnt: got %h expected 0000", sent_cnt); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", in_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_ready_rel: got %b expected 0", in_ready); end
    @(negedge clk);
    checks += 3;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_back: got %b expected 1", in_ready); end
    if (sent_cnt !== 16'h0) begin errors++; $display("FAIL abort_cnt_back: got %h expected 0000", sent_cnt); end
    if (en_out !== 1'b0) begin errors++; $display("FAIL abort_no_relaunch: got %b expected 0", en_out); end
  endtask

  task automatic test_wrap;
    bit ok;
    force dut_a.sent_q = 16'hFFFE;
    @(negedge clk);
    release dut_a.sent_q;
    exp_sent = 16'hFFFE;
    @(negedge clk);
    checks++;
    if (sent_cnt !== exp_sent) begin errors++; $display("FAIL wrap_preload: got %h expected %h", sent_cnt, exp_sent); end
    for (int w = 0; w < 2; w++) begin
      wait_ready(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL wrap_timeout: got no ready expected ready"); end
      in_valid = 1'b1;
      in_data  = (w == 0) ? 8'h77 : 8'h88;
      sbq.push_back(in_data);
      exp_sent++;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (sent_cnt !== exp_sent) begin errors++; $display("FAIL wrap_cnt%0d: got %h expected %h", w, sent_cnt, exp_sent); end
    end
    checks++;
    if (sent_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h expected 0000", sent_cnt); end
    wait_ready(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_drain: got no ready expected ready"); end
  endtask

  task automatic test_min_cfg;
    bit ok;
    logic [7:0] expd;
    logic [15:0] nx;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready_b) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL min_timeout: got no ready expected ready"); end
    nx = sent_cnt_b;
    in_valid_b = 1'b1;
    expd = 8'($urandom);
    in_data_b = expd;
    nx++;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks += 4;
      if (en_out_b !== (k % 3 == 1)) begin errors++; $display("FAIL min_en_k%0d: got %b expected %b", k, en_out_b, (k % 3 == 1)); end
      if (busy_b !== (k % 3 != 0)) begin errors++; $display("FAIL min_busy_k%0d: got %b expected %b", k, busy_b, (k % 3 != 0)); end
      if (in_ready_b !== (k % 3 == 0)) begin errors++; $display("FAIL min_ready_k%0d: got %b expected %b", k, in_ready_b, (k % 3 == 0)); end
      if (data_out_b !== expd) begin errors++; $display("FAIL min_data_k%0d: got %h expected %h", k, data_out_b, expd); end
      if (k % 3 == 0) begin
        expd = 8'($urandom);
        in_data_b = expd;
        nx++;
      end else begin
        in_data_b = 8'($urandom);
      end
    end
    @(negedge clk);
    in_valid_b = 1'b0;
    checks += 2;
    if (sent_cnt_b !== nx) begin errors++; $display("FAIL min_cnt: got %h expected %h", sent_cnt_b, nx); end
    if (data_out_b !== expd) begin errors++; $display("FAIL min_last_data: got %h expected %h", data_out_b, expd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_word();
    test_back_to_back();
    test_ignore();
    test_reset_abort();
    test_wrap();
    test_min_cfg();
    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() !== 0) begin errors++; $display("FAIL sb_leftover: got %0d expected 0", sbq.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_sync_launch.md
MUX_SYNC_LAUNCH -- requirements
Module: mux_sync_launch

Interface
REQ-001 Parameter DW, default 8, width of the data word.
REQ-002 Parameter HOLD, default 3, number of cycles en_out is held high per word (legal range 1..15).
REQ-003 Parameter GAP, default 3, number of cycles en_out is held low after each word before the next accept (legal range 1..15).
REQ-004 clk  input  1  launch-domain clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream has a word on in_data.
REQ-007 in_data  input  DW  word to launch.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 data_out  output  DW  registered launch data; feeds the destination-domain mux-ndff synchronizer data input.
REQ-010 en_out  output  1  registered launch enable; feeds the synchronizer enable input.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 sent_cnt  output  16  count of words accepted since reset.

Function
REQ-013 States SHALL be IDLE, HOLD and GAP, held in a registered state machine.
REQ-014 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL be registered: 0 during reset, 1 from the first edge after rst deasserts while in IDLE, 0 in HOLD and GAP.
REQ-016 On a transfer: data_out<=in_data, en_out<=1, state<=HOLD, hold counter<=HOLD-1, in_ready<=0, sent_cnt<=sent_cnt+1.
REQ-017 In HOLD: en_out stays 1; the counter decrements each edge; on the edge where the counter is 0, en_out<=0, state<=GAP, counter<=GAP-1.
REQ-018 In GAP: en_out stays 0; the counter decrements each edge; on the edge where the counter is 0, state<=IDLE and in_ready<=1.
REQ-019 en_out SHALL be high for exactly HOLD consecutive cycles per transfer, followed by at least GAP low cycles.
REQ-020 data_out SHALL change only on a transfer edge; it holds its value through HOLD, GAP and IDLE (stable for the whole en window plus the gap).
REQ-021 The minimum spacing between consecutive transfer edges SHALL be HOLD+GAP+1 cycles.
REQ-022 in_valid or in_data changes while in_ready=0 SHALL be ignored, with no effect on data_out or the counters.
REQ-023 sent_cnt SHALL wrap from 0xFFFF to 0x0000 with no flag.
REQ-024 busy SHALL equal (state != IDLE), decoded from registered state.
REQ-025 With HOLD=1, en_out SHALL be a single-cycle pulse; with GAP=1, exactly one low cycle precedes the return to IDLE.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, en_out=0, data_out=0, in_ready=0, sent_cnt=0 and counter=0, independent of clk.
REQ-027 Reset asserted mid-HOLD or mid-GAP SHALL abort the transfer: en_out drops asynchronously and the word is not relaunched.
REQ-028 On the first rising edge after rst deasserts, in_ready SHALL become 1; no transfer can occur on that edge.

Verification
REQ-029 Defaults, rst released, in_valid=1 and in_data=0xA5 held -> in_ready=1 after the first edge; transfer on the second edge; en_out=1 for exactly 3 cycles, then 0 for 3 cycles; data_out=0xA5 throughout; sent_cnt=1.
REQ-030 Back-to-back words 0x11 then 0x22 with in_valid held -> transfer edges 7 cycles apart; data_out changes 0x11->0x22 only on the second transfer edge, with en_out=0 at that moment.
REQ-031 in_data toggled every cycle during HOLD/GAP -> data_out unchanged, sent_cnt increments only on handshakes.
REQ-032 rst pulsed during the second HOLD cycle -> en_out=0 and data_out=0 with no clk edge needed; after release, in_ready returns to 1 one edge later and sent_cnt=0.
REQ-033 Preload 0xFFFF transfers (or force sent_cnt=0xFFFE) then send 2 words -> sent_cnt reads 0xFFFF then 0x0000.
REQ-034 HOLD=1, GAP=1 build -> single-cycle en_out pulses with a transfer every 3 cycles; in_ready=0 exactly while busy=1.
